data_mem_responder: RTL and testbench

Memory-side responder for the core's data memory port. It accepts one load or store at a time from the memory-access stage, holds `o_data_ready` low for a configurable number of wait states, then completes the access in a single acknowledge cycle. Stores honour per-byte lane enables. Load data is registered and masked. The block is the synthesizable data RAM used in core-level simulation and on FPGA, and it exercises the core's stall path through hazard control.

---
 rtl/data_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-side RAM responder for the core's memory-access stage. Accepts one
//   load or store at a time, stalls the core for WAIT_CYCLES wait states and
//   completes the access in a single acknowledge cycle. Stores honour byte
//   lane enables; load data is registered and masked by the same enables.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   i_data_addr    byte address; bits [1:0] ignored
//   i_data_wr      store data, lane aligned
//   i_data_be      byte-lane enables (store and load)
//   i_data_rd_en   load request
//   i_data_wr_en   store request (wins when both requests are high)
//   o_data_rd      registered load data, held until the next load completes
//   o_data_ready   low = stall; high when idle or acknowledging
//   o_data_err     one-cycle pulse in the ACK cycle of an illegal access

module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wr,
    input  logic [3:0]  i_data_be,
    input  logic        i_data_rd_en,
    input  logic        i_data_wr_en,
    output logic [31:0] o_data_rd,
    output logic        o_data_ready,
    output logic        o_data_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        wr_q, wr_d;
    logic        both_q, both_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          req;
    logic          access;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_wr;
    logic          acc_both;
    logic          acc_ok;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_rword;
    logic [31:0]   lane_mask;
    logic          unused_addr_bits;

    assign req = i_data_rd_en | i_data_wr_en;

    // With zero wait states the access happens on the same edge that latches
    // the request, so the access operands come straight from the inputs while
    // in IDLE and from the latched copy otherwise.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_addr  = i_data_addr;
            acc_wdata = i_data_wr;
            acc_be    = i_data_be;
            acc_wr    = i_data_wr_en;
            acc_both  = i_data_rd_en & i_data_wr_en;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
            acc_wr    = wr_q;
            acc_both  = both_q;
        end
    end

    assign acc_idx          = acc_addr[AW+1:2];
    assign acc_ok           = (acc_addr >> (AW + 2)) == 32'd0;
    assign acc_rword        = mem[acc_idx];
    assign lane_mask        = {{8{acc_be[3]}}, {8{acc_be[2]}}, {8{acc_be[1]}}, {8{acc_be[0]}}};
    assign unused_addr_bits = ^acc_addr[1:0];

    // True on the edge that enters ACK; gated by rst so nothing is written
    // while reset holds the FSM in IDLE.
    assign access = ~rst & (((state_q == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                            ((state_q == S_WAIT) && (cnt_q == 4'd0)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        both_d  = both_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = i_data_addr;
                    wdata_d = i_data_wr;
                    be_d    = i_data_be;
                    wr_d    = i_data_wr_en;
                    both_d  = i_data_rd_en & i_data_wr_en;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACK;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (access) begin
            err_d = ~acc_ok | acc_both;
            if (!acc_wr) rdata_d = acc_ok ? (acc_rword & lane_mask) : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            both_q  <= both_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (access && acc_wr && acc_ok) begin
            for (int n = 0; n < 4; n++) begin
                if (acc_be[n]) mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
            end
        end
    end

    always_comb begin
        if (rst)                     o_data_ready = 1'b0;
        else if (state_q == S_IDLE)  o_data_ready = ~req;
        else                         o_data_ready = (state_q == S_ACK);
    end

    assign o_data_rd  = rdata_q;
    assign o_data_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (2, 0 and 3 wait states)
// exercised by directed cases and random loads/stores checked against a
// word-array reference model.

module tb_data_mem_responder;

    localparam int DW  = 64;
    localparam int AWB = $clog2(DW) + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  rd_en;
    logic [2:0]  wr_en;
    logic [2:0]  ready;
    logic [2:0]  err;
    logic [31:0] addr [3];
    logic [31:0] wd   [3];
    logic [31:0] rdv  [3];
    logic [3:0]  be   [3];

    int wc [3] = '{2, 0, 3};

    logic [31:0] model_mem [3][DW];
    logic [31:0] model_rd  [3];

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst[0]), .i_data_addr(addr[0]), .i_data_wr(wd[0]),
        .i_data_be(be[0]), .i_data_rd_en(rd_en[0]), .i_data_wr_en(wr_en[0]),
        .o_data_rd(rdv[0]), .o_data_ready(ready[0]), .o_data_err(err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst[1]), .i_data_addr(addr[1]), .i_data_wr(wd[1]),
        .i_data_be(be[1]), .i_data_rd_en(rd_en[1]), .i_data_wr_en(wr_en[1]),
        .o_data_rd(rdv[1]), .o_data_ready(ready[1]), .o_data_err(err[1])
    );

    data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .rst(rst[2]), .i_data_addr(addr[2]), .i_data_wr(wd[2]),
        .i_data_be(be[2]), .i_data_rd_en(rd_en[2]), .i_data_wr_en(wr_en[2]),
        .o_data_rd(rdv[2]), .o_data_ready(ready[2]), .o_data_err(err[2])
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drives one request and waits for ready; inputs stay asserted on return
    // so a caller can issue back-to-back requests. Entered and left just
    // after a rising edge.
    task automatic txn(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output int lows, output logic [31:0] rdo, output logic erro);
        bit done;
        done = 0;
        lows = 0;
        rdo  = '0;
        erro = 1'b0;
        rd_en[k] = r;
        wr_en[k] = w;
        addr[k]  = a;
        wd[k]    = d;
        be[k]    = b;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready[k]) begin
                done = 1;
                rdo  = rdv[k];
                erro = err[k];
            end else begin
                lows++;
                check_val("err_in_stall", {31'd0, err[k]}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        if (!done) check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_req(input int k);
        rd_en[k] = 1'b0;
        wr_en[k] = 1'b0;
    endtask

    // Reference behaviour: a store writes enabled bytes of an in-range word;
    // a load replaces the held read data with the masked word (or 0 when out
    // of range); err flags out-of-range or double requests.
    task automatic model_step(input int k, input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b, output bit exp_err);
        bit          ok;
        int          idx;
        logic [31:0] m;
        ok  = (a >> AWB) == 0;
        idx = int'((a >> 2) % DW);
        for (int n = 0; n < 4; n++) m[8*n +: 8] = b[n] ? 8'hFF : 8'h00;
        if (w) begin
            if (ok) model_mem[k][idx] = (model_mem[k][idx] & ~m) | (d & m);
        end else begin
            model_rd[k] = ok ? (model_mem[k][idx] & m) : 32'd0;
        end
        exp_err = !ok || (r && w);
    endtask

    task automatic do_op(input int k, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, input string tag,
                         output logic [31:0] rdo);
        int   lows;
        logic e;
        bit   exp_err;
        model_step(k, r, w, a, d, b, exp_err);
        txn(k, r, w, a, d, b, lows, rdo, e);
        release_req(k);
        check_val({tag, "_lows"}, lows, wc[k] + 1);
        check_val({tag, "_rd"}, rdo, model_rd[k]);
        check_val({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] got;
        int          lows;
        logic        e;
        bit          exp_err;

        rst   = 3'b111;
        rd_en = '0;
        wr_en = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k]     = '0;
            wd[k]       = '0;
            be[k]       = '0;
            model_rd[k] = '0;
        end

        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check_val("rst_ready", {31'd0, ready[k]}, 32'd0);
                check_val("rst_rd", rdv[k], 32'd0);
                check_val("rst_err", {31'd0, err[k]}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        rst = 3'b000;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_val("post_rst_ready", {31'd0, ready[k]}, 32'd1);
        @(posedge clk);
        #1;

        // Preload the words the random phase uses so the model is fully known.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++)
                do_op(k, 0, 1, i * 4, $urandom, 4'hF, "preload", got);

        // Directed: round trip, byte lanes, empty enables, illegal accesses.
        do_op(0, 0, 1, 32'h10, 32'hA5A5_1234, 4'hF, "rt_st", got);
        do_op(0, 1, 0, 32'h10, 32'h0, 4'hF, "rt_ld", got);
        check_val("rt_const", got, 32'hA5A5_1234);
        do_op(0, 0, 1, 32'h10, 32'h0000_FF00, 4'b0010, "lane_st", got);
        do_op(0, 1, 0, 32'h10, 32'h0, 4'hF, "lane_ld", got);
        check_val("lane_const", got, 32'hA5A5_FF34);
        do_op(0, 1, 0, 32'h10, 32'h0, 4'b0001, "lane_ld1", got);
        check_val("lane1_const", got, 32'h0000_0034);
        do_op(0, 1, 0, 32'h10, 32'h0, 4'b0000, "be0_ld", got);
        check_val("be0_const", got, 32'h0);
        do_op(0, 1, 0, 4 * DW, 32'h0, 4'hF, "oob_ld", got);
        check_val("oob_const", got, 32'h0);
        do_op(0, 1, 0, 32'h10, 32'h0, 4'hF, "oob_keep", got);
        check_val("oob_keep_const", got, 32'hA5A5_FF34);
        do_op(0, 1, 1, 32'h30, 32'h1, 4'hF, "both", got);
        do_op(0, 1, 0, 32'h30, 32'h0, 4'hF, "both_ld", got);
        check_val("both_const", got, 32'h1);

        // Zero wait states: two back-to-back identical loads.
        do_op(1, 0, 1, 32'h10, 32'hA5A5_FF34, 4'hF, "z_st", got);
        for (int j = 0; j < 2; j++) begin
            txn(1, 1, 0, 32'h10, 32'h0, 4'hF, lows, got, e);
            check_val("b2b_lows", lows, 32'd1);
            check_val("b2b_rd", got, 32'hA5A5_FF34);
        end
        release_req(1);
        model_rd[1] = 32'hA5A5_FF34;

        // Reset abort on the 3-wait-state instance, in its 2nd WAIT cycle.
        do_op(2, 0, 1, 32'h20, 32'h1357_9BDF, 4'hF, "ab_pre", got);
        wr_en[2] = 1'b1;
        addr[2]  = 32'h20;
        wd[2]    = 32'hFFFF_FFFF;
        be[2]    = 4'hF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst[2]   = 1'b1;
        wr_en[2] = 1'b0;
        model_rd[2] = 32'd0;
        repeat (4) begin
            @(negedge clk);
            check_val("ab_ready", {31'd0, ready[2]}, 32'd0);
            check_val("ab_err", {31'd0, err[2]}, 32'd0);
            check_val("ab_rd", rdv[2], 32'd0);
        end
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        @(negedge clk);
        check_val("ab_rel_ready", {31'd0, ready[2]}, 32'd1);
        @(posedge clk);
        #1;
        do_op(2, 1, 0, 32'h20, 32'h0, 4'hF, "ab_ld", got);
        check_val("ab_const", got, 32'h1357_9BDF);

        // Random traffic on every instance.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40; i++) begin
                int          sel;
                bit          r, w;
                logic [31:0] a;
                logic [3:0]  b;
                sel = $urandom_range(0, 9);
                a   = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                b   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
                r   = (sel < 4) || (sel == 8);
                w   = !r || (sel == 8);
                if (sel == 9) a = (4 * DW) + $urandom_range(0, 1000);
                if (sel == 7) a = {1'b1, 31'($urandom)};
                do_op(k, r, w, a, $urandom, b, "rand", got);
            end
            for (int i = 0; i < 16; i++) do_op(k, 1, 0, i * 4, 32'h0, 4'hF, "sweep", got);
        end

        txn(0, 1, 0, 32'h0, 32'h0, 4'hF, lows, got, e);
        release_req(0);
        model_step(0, 1, 0, 32'h0, 32'h0, 4'hF, exp_err);
        check_val("final_rd", got, model_rd[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
